// File: rtl/load_unit.sv
// Load-side data path: issues one Avalon word read per load and returns the
// extended or merged writeback value with a one-cycle done pulse.
module load_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] rt_in,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] data_out,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] rt_q, rt_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [3:0]  mem_byteenable_q, mem_byteenable_d;
    logic [31:0] data_out_q, data_out_d;
    logic        error_q, error_d;

    logic        req_bad;
    logic [3:0]  req_be;
    logic [31:0] load_result;
    logic [31:0] rd_shr;
    logic [4:0]  lwl_sh;
    logic [4:0]  lwr_sh;
    logic [31:0] all_ones;

    // Request decode: lane enables and legality straight from the CPU inputs.
    always_comb begin
        req_bad = 1'b0;
        req_be  = 4'b0000;
        case (op)
            OP_LB, OP_LBU: req_be = 4'b0001 << addr[1:0];
            OP_LH, OP_LHU: begin
                req_be  = 4'b0011 << addr[1:0];
                req_bad = addr[0];
            end
            OP_LW: begin
                req_be  = 4'b1111;
                req_bad = (addr[1:0] != 2'b00);
            end
            OP_LWL: req_be = (4'b0010 << addr[1:0]) - 4'b0001;
            OP_LWR: req_be = 4'b1111 << addr[1:0];
            default: req_bad = 1'b1;
        endcase
    end

    // Lanes outside the enabled set fall off the ends of these shifts.
    always_comb begin
        all_ones    = '1;
        rd_shr      = mem_readdata >> {k_q, 3'b000};
        lwl_sh      = {~k_q, 3'b000};
        lwr_sh      = {k_q, 3'b000};
        load_result = mem_readdata;
        case (op_q)
            OP_LB:  load_result = {{24{rd_shr[7]}}, rd_shr[7:0]};
            OP_LBU: load_result = {24'h000000, rd_shr[7:0]};
            OP_LH:  load_result = {{16{rd_shr[15]}}, rd_shr[15:0]};
            OP_LHU: load_result = {16'h0000, rd_shr[15:0]};
            OP_LWL: load_result = (mem_readdata << lwl_sh) | (rt_q & ~(all_ones << lwl_sh));
            OP_LWR: load_result = rd_shr | (rt_q & ~(all_ones >> lwr_sh));
            default: load_result = mem_readdata;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        k_d              = k_q;
        rt_d             = rt_q;
        mem_address_d    = mem_address_q;
        mem_byteenable_d = mem_byteenable_q;
        data_out_d       = data_out_q;
        error_d          = error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_bad) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        error_d          = 1'b0;
                        op_d             = op;
                        k_d              = addr[1:0];
                        rt_d             = rt_in;
                        mem_address_d    = {addr[31:2], 2'b00};
                        mem_byteenable_d = req_be;
                        state_d          = S_READ;
                    end
                end
            end
            S_READ: begin
                if (!mem_waitrequest) begin
                    data_out_d = load_result;
                    state_d    = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            op_q             <= '0;
            k_q              <= '0;
            rt_q             <= '0;
            mem_address_q    <= '0;
            mem_byteenable_q <= '0;
            data_out_q       <= '0;
            error_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            k_q              <= k_d;
            rt_q             <= rt_d;
            mem_address_q    <= mem_address_d;
            mem_byteenable_q <= mem_byteenable_d;
            data_out_q       <= data_out_d;
            error_q          <= error_d;
        end
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        mem_read       = (state_q == S_READ);
        error          = error_q;
        data_out       = data_out_q;
        mem_address    = mem_address_q;
        mem_byteenable = mem_byteenable_q;
    end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Load-side data path: the read counterpart of the store byte/halfword/word filter.
- Takes a load request from the CPU execute stage and issues one Avalon-style word read on the data memory port, honouring waitrequest.
- Extracts, sign/zero-extends or merges (LWL/LWR) the returned lanes and hands the 32-bit writeback value to the register file with a one-cycle done pulse.
- Memory byte lane convention: lane k = readdata[8k+7:8k] for address offset k = addr[1:0].

Parameters:
- none

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  load request strobe; sampled only in IDLE
- op  input  6  MIPS opcode: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110
- addr  input  32  effective byte address
- rt_in  input  32  current rt value, used for LWL/LWR merge
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse: data_out/error valid
- error  output  1  valid with done: misaligned address or unsupported op
- data_out  output  32  writeback value, held until next done
- mem_address  output  32  word address {addr[31:2],2'b00}
- mem_read  output  1  Avalon read request
- mem_byteenable  output  4  active lanes
- mem_waitrequest  input  1  slave stall
- mem_readdata  input  32  read data, valid in the cycle mem_read=1 and mem_waitrequest=0

Behaviour:
- Reset values: busy=0, done=0, error=0, data_out=0, mem_read=0, mem_byteenable=0, mem_address=0; state IDLE.
- FSM states: IDLE, READ, DONE.
- IDLE:
  - start=1 with a valid, aligned op: latch op, addr[1:0], rt_in and address; go to READ.
  - start=1 with a bad op or misaligned address: latch error=1; go to DONE with no bus cycle.
  - start=0: stay in IDLE.
- Misalignment: LH/LHU with addr[0]=1; LW with addr[1:0]!=0. LB/LBU/LWL/LWR are never misaligned.
- READ:
  - mem_read=1; mem_address and mem_byteenable are registered and stable for the whole state.
  - mem_waitrequest=1: stay in READ.
  - mem_waitrequest=0: capture the result into data_out; go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE.
  - On an error, data_out keeps its previous value.
- Latency: start at cycle 0 with zero wait states gives mem_read in cycle 1 and done in cycle 2. Each wait cycle adds 1. The error path gives done in cycle 1.
- start while busy=1: ignored and not queued. The CPU must hold off until done.
- Byteenable by op, with k = addr[1:0]:
  - LB/LBU: 0001<<k
  - LH/LHU: 0011<<k
  - LW: 1111
  - LWL: (2^(k+1))-1
  - LWR: 1111<<k
- Result by op, with B = lane k byte and H = lanes k+1:k:
  - LB: sign-extend B. LBU: zero-extend B.
  - LH: sign-extend H. LHU: zero-extend H.
  - LW: full word.
  - LWL: data_out = (readdata << 8*(3-k)) merged with rt_in[8*(3-k)-1:0]. For k=3 the result is the full word.
  - LWR: data_out = readdata >> 8*k, upper 8*k bits taken from rt_in. For k=0 the result is the full word.
- Lanes outside byteenable: readdata bits there are don't-care and must not affect the result.
- Reset mid-operation: at the reset edge go to IDLE, with mem_read=0 and done=0 from the next cycle. A late readdata is ignored.

Test Plan:
- LW addr=0x100, readdata=0xDEADBEEF, 0 waits -> byteenable=1111, mem_address=0x100; done in cycle 2 with data_out=0xDEADBEEF, error=0.
- LB vs LBU at addr=0x103, readdata=0x80FF7F01 -> byteenable=1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- LH addr=0x202, readdata=0x8001AAAA, 3 waitrequest cycles -> mem_read held 4 cycles with address and byteenable stable; done in cycle 5 with data_out=0xFFFF8001.
- LWL addr=0x301 and LWR addr=0x301, rt_in=0x11223344, readdata=0xAABBCCDD:
  - LWL -> byteenable=0011, data_out=0xCCDD3344.
  - LWR -> byteenable=1110, data_out=0x11AABBCC.
- LW addr=0x102 and LH addr=0x101; also op=101011 -> mem_read never asserted; done in cycle 1 with error=1 and data_out unchanged.
- Reset mid-read (waitrequest=1) followed by a start pulse while busy -> idle outputs after the reset edge; the busy-time start does not launch a second read, checked by counting mem_read cycles.
